display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Time-shares one seven-segment display (8-bit value input) between NUM_SRC producers.
- Each producer posts an 8-bit value into its own slot through a valid/ready handshake.
- The scheduler rotates round-robin through active slots, showing each for DWELL_CYCLES clocks, and drives the display's value input plus channel and blank indicators.
- Sits between system producers and the seven_segment instance.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DWELL_CYCLES, 50000000, clocks each active channel is displayed (>=2).
- CW, $clog2(NUM_SRC), channel index width (derived).
- DCW, $clog2(DWELL_CYCLES), dwell counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source write strobe.
- src_value  in  8*NUM_SRC  packed values; source i at bits [8i+7:8i].
- src_clear  in  NUM_SRC  per-source deactivate request (1-cycle pulse).
- src_ready  out  NUM_SRC  slot accepts write.
- hold  in  1  freeze rotation on the current channel.
- value  out  8  value to the seven_segment value input.
- chan  out  CW  index of the channel shown.
- blank  out  1  1 = no active channel; the display shows 0.
- switch_pulse  out  1  one-cycle strobe when a new channel is selected.

Behaviour:
- Reset (async, any time, including mid-dwell):
  - All slot values = 0; all active bits = 0.
  - value = 0, chan = 0, blank = 1, switch_pulse = 0, src_ready = 0.
  - State = IDLE, dwell_cnt = 0.
- src_ready is a registered copy of "not in reset": it is 0 during reset and for the first clock after rst falls, then 1 permanently.
- Write:
  - src_valid[i] & src_ready[i] loads slot[i] and sets active[i] at the clock edge.
  - Writes to the displayed slot appear on value one clock later (registered).
- Clear:
  - src_clear[i] clears active[i]; the slot value is retained.
  - src_valid[i] and src_clear[i] in the same cycle: valid wins (load, active stays 1).
- States:
  - IDLE:
    - blank = 1, value = 0.
    - If any active bit is set: go to SWITCH, searching from index 0 inclusive.
  - SHOW:
    - value = slot[chan], blank = 0.
    - dwell_cnt increments each clock unless hold = 1.
    - At dwell_cnt == DWELL_CYCLES-1 (with hold = 0): go to SWITCH.
    - If active[chan] is cleared: go to SWITCH immediately, regardless of hold or the count.
  - SWITCH (exactly 1 clock):
    - Select the next active index strictly after chan, wrapping modulo NUM_SRC. The search starts at 0 inclusive when entered from IDLE. If chan is the only active channel, chan is re-selected.
    - If none is active: go to IDLE; blank = 1 and value = 0 on the following clock.
    - Otherwise: chan <= selected index, dwell_cnt <= 0, switch_pulse = 1 for this cycle, go to SHOW.
    - value holds its previous content during SWITCH (no glitch to 0).
- Latency:
  - First write from IDLE to non-blank output: 3 clocks (slot load, IDLE->SWITCH, SWITCH->SHOW).
  - Each channel occupies exactly DWELL_CYCLES SHOW clocks plus 1 SWITCH clock.
- Active bits are sampled as updated in the same clock. A channel activated during SWITCH is considered on the next selection, not the current one.
- hold = 1 in IDLE or SWITCH has no effect.

Decomposition:
- Package display_pkg:
  - State encoding (IDLE = 2'd0, SHOW = 2'd1, SWITCH = 2'd2).
  - Default DWELL_CYCLES constant.
- One sub-module, rr_next_select: combinational next-active-index search.
  - Inputs: active mask, current index, from_zero flag.
  - Outputs: found, index.
  - Reusable by other arbiters.

Test Plan:
- Reset then idle: rst high 30 ns, release, no writes. Required: blank = 1, value = 0, src_ready rises one clock after release, switch_pulse never asserts.
- Single source (DWELL_CYCLES = 4): write 37 to source 2. Required: switch_pulse 2 clocks later, then chan = 2, value = 37, blank = 0. chan stays 2 with switch_pulse every 5 clocks.
- Rotation (DWELL_CYCLES = 4): write 0 to source 0, 128 to source 1, 255 to source 3. Required sequence: chan 0 -> 1 -> 3 -> 0, value 0 -> 128 -> 255 -> 0, each value held for 4 clocks with a 1-clock SWITCH between.
- Hold and clear: with 3 sources rotating, assert hold on chan 1 for 20 clocks; value stays 128. Pulse src_clear[1] while hold = 1. Required: SWITCH the next clock, then chan = 3.
- Simultaneous events: src_valid[0] = 1 with value 64 together with src_clear[0]. Required: active[0] stays set and chan 0 later shows 64. Clearing all sources returns the block to IDLE: blank = 1 and value = 0 one clock after SWITCH.
- Reset mid-dwell: assert rst for 50 ns during SHOW on chan 3. Required: immediate blank = 1, value = 0, chan = 0. After release, old slot contents are gone. Writing 64 to source 0 displays 64 after 3 clocks.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared state encoding and default dwell time for the display
//               scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHOW   = 2'd1;
    localparam logic [1:0] c_SWITCH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = c_IDLE,
        S_SHOW   = c_SHOW,
        S_SWITCH = c_SWITCH
    } state_t;

    localparam int c_DWELL_CYCLES_DEFAULT = 50_000_000;

endpackage : display_pkg
`default_nettype wire

// File: rtl/rr_next_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_next_select
// Description : Combinational round-robin search for the next set bit in a
//               mask, strictly after cur (wrapping) or from index 0 inclusive.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_next_select #(
    parameter int NUM_SRC = 4,
    parameter int CW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] active,
    input  logic [CW-1:0]      cur,
    input  logic               from_zero,
    output logic               found,
    output logic [CW-1:0]      index
);

    // Candidate k is the k-th index visited; the last one wraps back to cur.
    logic [CW-1:0] w_cand [NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_cand
        assign w_cand[k] = from_zero ? CW'(k)
                                     : CW'((int'(cur) + 1 + k) % NUM_SRC);
    end

    // Scan from the far end so the earliest candidate overwrites the rest.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (active[w_cand[k]]) begin
                found = 1'b1;
                index = w_cand[k];
            end
        end
    end

endmodule : rr_next_select
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler
// Description : Time-shares one seven-segment value input between NUM_SRC
//               producers, rotating round-robin over the active slots.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler
    import display_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = c_DWELL_CYCLES_DEFAULT,
    parameter int CW           = $clog2(NUM_SRC),
    parameter int DCW          = $clog2(DWELL_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_value,
    input  logic [NUM_SRC-1:0]   src_clear,
    output logic [NUM_SRC-1:0]   src_ready,
    input  logic                 hold,
    output logic [7:0]           value,
    output logic [CW-1:0]        chan,
    output logic                 blank,
    output logic                 switch_pulse
);

    localparam logic [DCW-1:0] c_DWELL_LAST = DCW'(DWELL_CYCLES - 1);

    logic [7:0]         r_slot [NUM_SRC];
    logic [NUM_SRC-1:0] r_active;
    logic               r_ready;
    state_t             r_state;
    logic [CW-1:0]      r_chan;
    logic [DCW-1:0]     r_dwell;
    logic [7:0]         r_value;
    logic               r_blank;
    logic               r_from_zero;

    logic               w_found;
    logic [CW-1:0]      w_sel;

    rr_next_select #(
        .NUM_SRC (NUM_SRC),
        .CW      (CW)
    ) u_rr_next_select (
        .active    (r_active),
        .cur       (r_chan),
        .from_zero (r_from_zero),
        .found     (w_found),
        .index     (w_sel)
    );

    // Slot storage: a write beats a simultaneous clear, clear keeps the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready  <= 1'b0;
            r_active <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_slot[i] <= 8'd0;
            end
        end else begin
            r_ready <= 1'b1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && r_ready) begin
                    r_slot[i]   <= src_value[8*i +: 8];
                    r_active[i] <= 1'b1;
                end else if (src_clear[i]) begin
                    r_active[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_chan      <= '0;
            r_dwell     <= '0;
            r_value     <= 8'd0;
            r_blank     <= 1'b1;
            r_from_zero <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_value     <= 8'd0;
                    r_blank     <= 1'b1;
                    r_from_zero <= 1'b1;
                    if (|r_active) begin
                        r_state <= S_SWITCH;
                    end
                end
                S_SHOW: begin
                    r_value     <= r_slot[r_chan];
                    r_from_zero <= 1'b0;
                    // Losing the active bit ends the dwell even under hold.
                    if (!r_active[r_chan]) begin
                        r_state <= S_SWITCH;
                    end else if (!hold) begin
                        if (r_dwell == c_DWELL_LAST) begin
                            r_state <= S_SWITCH;
                        end else begin
                            r_dwell <= r_dwell + DCW'(1);
                        end
                    end
                end
                S_SWITCH: begin
                    r_dwell <= '0;
                    if (w_found) begin
                        r_chan  <= w_sel;
                        r_value <= r_slot[w_sel];
                        r_blank <= 1'b0;
                        r_state <= S_SHOW;
                    end else begin
                        r_value <= 8'd0;
                        r_blank <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign src_ready    = {NUM_SRC{r_ready}};
    assign value        = r_value;
    assign chan         = r_chan;
    assign blank        = r_blank;
    assign switch_pulse = (r_state == S_SWITCH) && w_found;

endmodule : display_scheduler
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scheduler
// Description : Directed bench for display_scheduler (NUM_SRC=4, DWELL=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DWELL   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_valid;
    logic [31:0] src_value;
    logic [3:0]  src_clear;
    logic [3:0]  src_ready;
    logic        hold;
    logic [7:0]  value;
    logic [1:0]  chan;
    logic        blank;
    logic        switch_pulse;

    int checks = 0;
    int errors = 0;

    int rot_chan [3] = '{0, 1, 3};
    int rot_val  [3] = '{0, 128, 255};

    display_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_value    (src_value),
        .src_clear    (src_clear),
        .src_ready    (src_ready),
        .hold         (hold),
        .value        (value),
        .chan         (chan),
        .blank        (blank),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_pulse(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (switch_pulse === 1'b1) seen = 1'b1;
            else step();
        end
    endtask

    logic seen;

    initial begin
        rst = 1'b1; src_valid = '0; src_clear = '0; src_value = '0; hold = 1'b0;

        // Reset and idle
        step();
        check("rst_blank", blank, 1);
        check("rst_value", value, 0);
        check("rst_chan", chan, 0);
        check("rst_pulse", switch_pulse, 0);
        check("rst_ready", src_ready, 0);
        step(); step();
        rst = 1'b0;
        #1;
        check("ready_first_clock", src_ready, 0);
        step();
        check("ready_up", src_ready, 4'hF);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_blank", blank, 1);
            check("idle_value", value, 0);
            check("idle_pulse", switch_pulse, 0);
        end

        // Single source: 37 on source 2
        src_valid = 4'b0100; src_value[23:16] = 8'd37;
        step();
        src_valid = '0;
        check("ss_pulse_c1", switch_pulse, 0);
        check("ss_blank_c1", blank, 1);
        step();
        check("ss_pulse_c2", switch_pulse, 1);
        check("ss_value_c2", value, 0);
        step();
        for (int k = 0; k < 10; k++) begin
            check("ss_chan", chan, 2);
            check("ss_value", value, 37);
            check("ss_blank", blank, 0);
            check("ss_pulse", switch_pulse, (k % 5 == 4) ? 1 : 0);
            step();
        end

        // Rotation over sources 0, 1, 3 from a clean state
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        src_valid = 4'b1011; src_value = {8'd255, 8'd0, 8'd128, 8'd0};
        step();
        src_valid = '0;
        step();
        check("rot_first_pulse", switch_pulse, 1);
        step();
        for (int k = 0; k < 17; k++) begin
            check("rot_chan", chan, rot_chan[(k / 5) % 3]);
            check("rot_value", value, rot_val[(k / 5) % 3]);
            check("rot_blank", blank, 0);
            check("rot_pulse", switch_pulse, (k % 5 == 4) ? 1 : 0);
            step();
        end

        // Hold on channel 1, then clear it while held
        step(); step(); step();
        check("hold_entry_chan", chan, 1);
        check("hold_entry_value", value, 128);
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_value", value, 128);
            check("hold_chan", chan, 1);
            check("hold_pulse", switch_pulse, 0);
        end
        src_clear = 4'b0010;
        step();
        src_clear = '0;
        wait_pulse(3, seen);
        check("clear_switch_seen", seen, 1);
        step();
        check("clear_next_chan", chan, 3);
        check("clear_next_value", value, 255);
        hold = 1'b0;

        // Valid and clear together on source 0: valid wins
        src_valid = 4'b0001; src_clear = 4'b0001; src_value[7:0] = 8'd64;
        step();
        src_valid = '0; src_clear = '0;
        wait_pulse(8, seen);
        check("simul_switch_seen", seen, 1);
        step();
        check("simul_chan", chan, 0);
        check("simul_value", value, 64);
        check("simul_blank", blank, 0);

        // Clearing everything returns to idle
        src_clear = 4'hF;
        step();
        src_clear = '0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (blank === 1'b1) seen = 1'b1;
        end
        check("idle_return_seen", seen, 1);
        check("idle_return_value", value, 0);
        check("idle_return_pulse", switch_pulse, 0);

        // Reset in the middle of a dwell on channel 3
        src_valid = 4'b1000; src_value[31:24] = 8'd255;
        step();
        src_valid = '0;
        step(); step();
        check("mid_chan", chan, 3);
        check("mid_value", value, 255);
        step();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_blank", blank, 1);
        check("mid_rst_value", value, 0);
        check("mid_rst_chan", chan, 0);
        check("mid_rst_ready", src_ready, 0);
        #45;
        step();
        rst = 1'b0;
        step();
        check("mid_ready", src_ready, 4'hF);
        src_valid = 4'b0001; src_value = '0; src_value[7:0] = 8'd64;
        step();
        src_valid = '0;
        check("post_blank_c1", blank, 1);
        step();
        check("post_blank_c2", blank, 1);
        check("post_pulse_c2", switch_pulse, 1);
        step();
        check("post_value", value, 64);
        check("post_chan", chan, 0);
        check("post_blank", blank, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_only_chan0", chan, 0);
            check("post_only_value", value, 64);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule : tb_display_scheduler
`default_nettype wire
